// File: rtl/neuron.sv
// Leaky integrate-and-fire neuron. Each cycle the weights of the active synapses
// are summed and added to the membrane potential, and a constant leak is removed.
// When the potential reaches threshold the neuron broadcasts a one-cycle spike
// tagged with its address, clears the potential, and ignores input for a
// refractory window.
module neuron #(
  parameter int                          NUM_SYN     = 32,
  parameter int                          VWIDTH      = 16,
  parameter int                          WWIDTH      = 8,
  parameter logic [NUM_SYN*WWIDTH-1:0]   WEIGHTS     = {32{8'd4}},
  parameter int                          LEAK        = 1,
  parameter int                          THRESHOLD   = 20,
  parameter int                          REFRACTORY  = 2,
  parameter logic [31:0]                 NEURON_ADDR = 32'd0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_SYN-1:0] SpikeIn,
  output logic [31:0]        SpikeOut,
  output logic [31:0]        SourceAddr
);

  // Sum width covers NUM_SYN max-valued weights with headroom; the extended
  // width holds either operand plus a carry so the saturating add never wraps.
  localparam int SUMW = WWIDTH + $clog2(NUM_SYN) + 1;
  localparam int EW   = ((VWIDTH > SUMW) ? VWIDTH : SUMW) + 1;
  localparam int RW   = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  localparam logic [EW-1:0] VMAX = {{(EW-VWIDTH){1'b0}}, {VWIDTH{1'b1}}};
  localparam logic [EW-1:0] LK   = EW'(LEAK);
  localparam logic [EW-1:0] THR  = EW'(THRESHOLD);

  logic [VWIDTH-1:0] v_q,     v_d;
  logic [RW-1:0]     ref_q,   ref_d;
  logic [31:0]       spike_q, spike_d;
  logic [31:0]       addr_q,  addr_d;

  logic [NUM_SYN-1:0][SUMW-1:0] wgt;
  logic [SUMW-1:0]              sum;
  logic [EW-1:0]                add_raw, add_sat, v_next;
  logic                         fire;

  // Per-synapse gating: an active line contributes its weight, else zero.
  for (genvar i = 0; i < NUM_SYN; i++) begin : g_syn
    assign wgt[i] = SpikeIn[i] ? SUMW'(WEIGHTS[i*WWIDTH +: WWIDTH]) : '0;
  end

  // Full-width reduction of the gated weights.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SYN; i++) sum = sum + wgt[i];
  end

  // Integrate with saturation at the top of the potential range, then leak
  // with a floor at zero; the threshold test uses the extended result.
  always_comb begin
    add_raw = EW'(v_q) + EW'(sum);
    add_sat = (add_raw > VMAX) ? VMAX : add_raw;
    v_next  = (add_sat >= LK) ? (add_sat - LK) : '0;
    fire    = (v_next >= THR);
  end

  // Next-state: refractory hold, fire, or plain integration.
  always_comb begin
    v_d     = v_q;
    ref_d   = ref_q;
    spike_d = '0;
    addr_d  = '0;
    if (ref_q != '0) begin
      v_d   = '0;
      ref_d = ref_q - 1'b1;
    end else if (fire) begin
      v_d     = '0;
      ref_d   = RW'(REFRACTORY);
      spike_d = '1;
      addr_d  = NEURON_ADDR;
    end else begin
      v_d = v_next[VWIDTH-1:0];
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v_q     <= '0;
      ref_q   <= '0;
      spike_q <= '0;
      addr_q  <= '0;
    end else begin
      v_q     <= v_d;
      ref_q   <= ref_d;
      spike_q <= spike_d;
      addr_q  <= addr_d;
    end
  end

  assign SpikeOut   = spike_q;
  assign SourceAddr = addr_q;

endmodule

// File: tb/tb_neuron.sv
// Bench for neuron: a default-configured instance (with a distinct address),
// a saturation instance (8-bit potential, max weights) and a zero-refractory
// instance. Expected values come from a behavioural model pushed to a queue.
module tb_neuron;

  localparam logic [31:0] ADDR   = 32'hA5A5_0017;
  localparam logic [31:0] ADDR_Z = 32'h0000_0C0D;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] spk, spk_s, spk_z;
  logic [31:0] so, sa, so_s, sa_s, so_z, sa_z;

  always #5 Clk = ~Clk;

  neuron #(.NEURON_ADDR(ADDR)) dut (
    .Clk(Clk), .Rst(Rst), .SpikeIn(spk), .SpikeOut(so), .SourceAddr(sa));

  neuron #(.VWIDTH(8), .WEIGHTS({32{8'd255}}), .THRESHOLD(255), .LEAK(0)) dut_s (
    .Clk(Clk), .Rst(Rst), .SpikeIn(spk_s), .SpikeOut(so_s), .SourceAddr(sa_s));

  neuron #(.REFRACTORY(0), .NEURON_ADDR(ADDR_Z)) dut_z (
    .Clk(Clk), .Rst(Rst), .SpikeIn(spk_z), .SpikeOut(so_z), .SourceAddr(sa_z));

  typedef struct { logic fire; int v; } exp_t;
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mv, mcnt;

  // Behavioural model of the default instance (weights 4, leak 1, thr 20, refr 2).
  task automatic model_push(input logic [31:0] s);
    exp_t e;
    int   v;
    if (mcnt != 0) begin
      mcnt = mcnt - 1;
      mv = 0;
      e.fire = 1'b0;
    end else begin
      v = mv + 4 * $countones(s);
      if (v > 65535) v = 65535;
      v = (v >= 1) ? v - 1 : 0;
      if (v >= 20) begin
        mv = 0; mcnt = 2; e.fire = 1'b1;
      end else begin
        mv = v; e.fire = 1'b0;
      end
    end
    e.v = mv;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b0; spk = '0; spk_s = '0; spk_z = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    mv = 0; mcnt = 0;
    sbq.delete();
  endtask

  task automatic test_reset();
    Rst = 1'b0; spk = '1; spk_s = '1; spk_z = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      total++;
      if (so !== 32'h0 || sa !== 32'h0 || dut.v_q !== 16'd0 || dut.ref_q !== 2'd0 ||
          so_s !== 32'h0 || so_z !== 32'h0 || sa_z !== 32'h0) begin
        bad++;
        $display("FAIL reset c=%0d so=%h sa=%h v=%0d ref=%0d so_s=%h so_z=%h want all 0",
                 c, so, sa, dut.v_q, dut.ref_q, so_s, so_z);
      end
    end
    spk = '0; spk_s = '0; spk_z = '0;
    Rst = 1'b1;
    mv = 0; mcnt = 0;
  endtask

  task automatic test_alternate();
    exp_t e;
    int   fire_at = -1;
    int   nfire   = 0;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      spk = (i % 2 == 0) ? 32'h1 : 32'h0;
      model_push(spk);
      @(negedge Clk);
      e = sbq.pop_front();
      total++;
      if (so !== (e.fire ? 32'hFFFF_FFFF : 32'h0) || sa !== (e.fire ? ADDR : 32'h0) ||
          dut.v_q !== 16'(e.v)) begin
        bad++;
        $display("FAIL alternate i=%0d so=%h sa=%h v=%0d want fire=%0b v=%0d",
                 i, so, sa, dut.v_q, e.fire, e.v);
      end
      if (i % 2 == 0 && i < 18) begin
        total++;
        if (dut.v_q !== 16'(i + 3)) begin
          bad++;
          $display("FAIL alt_ramp i=%0d v=%0d want %0d", i, dut.v_q, i + 3);
        end
      end
      if (so !== 32'h0) begin fire_at = i; nfire++; end
    end
    total++;
    if (fire_at != 18 || nfire != 1 || dut.v_q !== 16'd3) begin
      bad++;
      $display("FAIL alt_fire at=%0d n=%0d vend=%0d want at=18 n=1 vend=3", fire_at, nfire, dut.v_q);
    end
  endtask

  task automatic test_leak();
    exp_t e;
    logic [31:0] pat [13] = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      spk = pat[i];
      model_push(spk);
      @(negedge Clk);
      e = sbq.pop_front();
      total++;
      if (so !== 32'h0 || e.fire || dut.v_q !== 16'(e.v)) begin
        bad++;
        $display("FAIL leak i=%0d so=%h v=%0d want so=0 v=%0d", i, so, dut.v_q, e.v);
      end
    end
    total++;
    if (dut.v_q !== 16'd0) begin
      bad++;
      $display("FAIL leak_floor v=%0d want 0", dut.v_q);
    end
  endtask

  task automatic test_burst();
    exp_t e;
    logic [31:0] pat [4] = '{32'h1F, 32'h1F, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      spk = pat[i];
      model_push(spk);
      @(negedge Clk);
      e = sbq.pop_front();
      total++;
      if (so !== (e.fire ? 32'hFFFF_FFFF : 32'h0) || sa !== (e.fire ? ADDR : 32'h0) ||
          dut.v_q !== 16'(e.v)) begin
        bad++;
        $display("FAIL burst i=%0d so=%h sa=%h v=%0d want fire=%0b v=%0d",
                 i, so, sa, dut.v_q, e.fire, e.v);
      end
      if (i == 0) begin
        total++;
        if (dut.v_q !== 16'd19 || so !== 32'h0) begin
          bad++;
          $display("FAIL burst_first v=%0d so=%h want v=19 so=0", dut.v_q, so);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      spk = $urandom & $urandom & $urandom;
      model_push(spk);
      @(negedge Clk);
      e = sbq.pop_front();
      total++;
      if (so !== (e.fire ? 32'hFFFF_FFFF : 32'h0) || sa !== (e.fire ? ADDR : 32'h0) ||
          dut.v_q !== 16'(e.v)) begin
        bad++;
        $display("FAIL random i=%0d in=%h so=%h sa=%h v=%0d want fire=%0b v=%0d",
                 i, spk, so, sa, dut.v_q, e.fire, e.v);
      end
    end
    spk = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    spk_s = '1;
    @(negedge Clk);
    total++;
    if (so_s !== 32'hFFFF_FFFF || sa_s !== 32'h0 || dut_s.v_q !== 8'd0) begin
      bad++;
      $display("FAIL saturate so=%h sa=%h v=%0d want so=ffffffff sa=0 v=0", so_s, sa_s, dut_s.v_q);
    end
    spk_s = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++;
      if (so_s !== 32'h0 || dut_s.v_q !== 8'd0) begin
        bad++;
        $display("FAIL sat_after i=%0d so=%h v=%0d want so=0 v=0", i, so_s, dut_s.v_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    spk_z = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++;
      if (so_z !== 32'hFFFF_FFFF || sa_z !== ADDR_Z) begin
        bad++;
        $display("FAIL b2b i=%0d so=%h sa=%h want so=ffffffff sa=%h", i, so_z, sa_z, ADDR_Z);
      end
    end
    spk_z = '0;
    @(negedge Clk);
    total++;
    if (so_z !== 32'h0 || sa_z !== 32'h0) begin
      bad++;
      $display("FAIL b2b_end so=%h sa=%h want 0", so_z, sa_z);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // reach a fire: 19 then 38
    spk = 32'h1F;
    repeat (2) @(negedge Clk);
    spk = 32'h0;
    total++;
    if (so !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL mid_prefire so=%h want ffffffff", so);
    end
    // reset while the fire is on the outputs
    #2 Rst = 1'b0;
    #1;
    total++;
    if (so !== 32'h0 || sa !== 32'h0 || dut.ref_q !== 2'd0 || dut.v_q !== 16'd0) begin
      bad++;
      $display("FAIL mid_fire_rst so=%h sa=%h ref=%0d v=%0d want 0", so, sa, dut.ref_q, dut.v_q);
    end
    @(negedge Clk);
    Rst = 1'b1;
    // fire again, then reset one cycle into refractory
    spk = 32'h1F;
    repeat (2) @(negedge Clk);
    spk = 32'h0;
    @(negedge Clk);
    total++;
    if (dut.ref_q !== 2'd1 || so !== 32'h0) begin
      bad++;
      $display("FAIL mid_refr ref=%0d so=%h want ref=1 so=0", dut.ref_q, so);
    end
    #2 Rst = 1'b0;
    #1;
    total++;
    if (dut.ref_q !== 2'd0 || dut.v_q !== 16'd0 || so !== 32'h0 || sa !== 32'h0) begin
      bad++;
      $display("FAIL mid_refr_rst ref=%0d v=%0d so=%h want 0", dut.ref_q, dut.v_q, so);
    end
    @(negedge Clk);
    Rst = 1'b1;
    spk = 32'h1;
    @(negedge Clk);
    spk = 32'h0;
    total++;
    if (dut.v_q !== 16'd3 || so !== 32'h0) begin
      bad++;
      $display("FAIL mid_release v=%0d so=%h want v=3 so=0", dut.v_q, so);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_leak();
    test_burst();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
